// File: rtl/yuv2bgr_pipe.sv
// ============================================================================
// yuv2bgr_pipe
// ----------------------------------------------------------------------------
// Pipelined YCbCr -> BGR colour-space converter. It accepts one pixel per
// clock and has a fixed latency of three register stages. The BT.601 or
// BT.709 matrix is chosen for each pixel. Results are rounded and saturated
// to [0, 2^DW-1].
//
// Stage 1 : offset removal (y' = Y-16<<S, u' = U-128<<S, v' = V-128<<S)
// Stage 2 : five coefficient products, coefficients muxed by the pixel's sel
// Stage 3 : sums + rounding, >>> 12, saturation into out_bgr
//
// All stages advance together on en = ~out_valid | out_ready. Bubbles are
// not squeezed out of the pipe.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous active-high reset
//   in_valid   in   1       input pixel valid
//   in_ready   out  1       pixel accepted this cycle if in_valid
//   in_yuv     in   3*DW    {Y, U(Cb), V(Cr)}, unsigned, Y in MSBs
//   in_sel709  in   1       0 = BT.601, 1 = BT.709 (per pixel)
//   in_sb      in   SB_W    sideband, travels unchanged with the pixel
//   out_valid  out  1       output pixel valid
//   out_ready  in   1       downstream accepts
//   out_bgr    out  3*DW    {B, G, R}, unsigned, saturated, B in MSBs
//   out_sb     out  SB_W    sideband of the pixel on out_bgr
// ============================================================================
module yuv2bgr_pipe #(
    parameter int DW   = 8,
    parameter int SB_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3*DW-1:0]   in_yuv,
    input  logic              in_sel709,
    input  logic [SB_W-1:0]   in_sb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3*DW-1:0]   out_bgr,
    output logic [SB_W-1:0]   out_sb
);

    localparam int S     = DW - 8;
    localparam int FRAC  = 12;
    // The largest coefficient is 14 bits and the offset sample is DW+1 bits.
    // A sum of three such products fits in DW+18 bits with margin.
    localparam int ACC_W = DW + 18;

    typedef logic signed [ACC_W-1:0] acc_t;

    localparam logic [DW:0] Y_OFS = (DW+1)'(16)  << S;
    localparam logic [DW:0] C_OFS = (DW+1)'(128) << S;

    localparam acc_t KY      = acc_t'(4768);
    localparam acc_t KRV_601 = acc_t'(6537);
    localparam acc_t KGU_601 = acc_t'(1606);
    localparam acc_t KGV_601 = acc_t'(3330);
    localparam acc_t KBU_601 = acc_t'(8262);
    localparam acc_t KRV_709 = acc_t'(7344);
    localparam acc_t KGU_709 = acc_t'(872);
    localparam acc_t KGV_709 = acc_t'(2183);
    localparam acc_t KBU_709 = acc_t'(8651);
    localparam acc_t RND     = acc_t'(2048);
    localparam acc_t MAXV    = acc_t'((1 << DW) - 1);

    logic en;

    // Stage 1
    logic                 s1_valid;
    logic signed [DW:0]   s1_y, s1_u, s1_v;
    logic                 s1_sel;
    logic [SB_W-1:0]      s1_sb;

    // Stage 2
    logic                 s2_valid;
    acc_t                 p_y, p_rv, p_gu, p_gv, p_bu;
    logic [SB_W-1:0]      s2_sb;

    // Combinational helpers
    acc_t y_e, u_e, v_e;
    acc_t k_rv, k_gu, k_gv, k_bu;
    acc_t r_acc, g_acc, b_acc;

    // Single advance enable. It is the only combinational path from out_ready
    // through to in_ready.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Rounding has already been added, so the arithmetic shift floors the
    // value. The result is then clamped into the output range.
    function automatic logic [DW-1:0] sat(input acc_t a);
        acc_t sh;
        sh = a >>> FRAC;
        if (sh[ACC_W-1])
            return '0;
        else if (sh > MAXV)
            return '1;
        else
            return sh[DW-1:0];
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first. A path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        y_e  = {{(ACC_W-DW-1){s1_y[DW]}}, s1_y};
        u_e  = {{(ACC_W-DW-1){s1_u[DW]}}, s1_u};
        v_e  = {{(ACC_W-DW-1){s1_v[DW]}}, s1_v};
        k_rv = KRV_601;
        k_gu = KGU_601;
        k_gv = KGV_601;
        k_bu = KBU_601;
        // The sel registered with this pixel picks the coefficients. Pixels
        // that mix matrices back to back therefore never pick up a
        // neighbour's matrix.
        if (s1_sel) begin
            k_rv = KRV_709;
            k_gu = KGU_709;
            k_gv = KGV_709;
            k_bu = KBU_709;
        end
        r_acc = p_y + p_rv + RND;
        g_acc = p_y - p_gu - p_gv + RND;
        b_acc = p_y + p_bu + RND;
    end

    // NOTE: datapath registers have no reset. Their contents are only
    // observed behind a valid flag, and the valid flags do get reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_y   <= {1'b0, in_yuv[3*DW-1 -: DW]} - Y_OFS;
            s1_u   <= {1'b0, in_yuv[2*DW-1 -: DW]} - C_OFS;
            s1_v   <= {1'b0, in_yuv[DW-1:0]}       - C_OFS;
            s1_sel <= in_sel709;
            s1_sb  <= in_sb;

            p_y    <= y_e * KY;
            p_rv   <= v_e * k_rv;
            p_gu   <= u_e * k_gu;
            p_gv   <= v_e * k_gv;
            p_bu   <= u_e * k_bu;
            s2_sb  <= s1_sb;
        end
    end

    // NOTE: sequential state uses non-blocking assignments. All stages then
    // sample their predecessor's old value on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_bgr   <= '0;
            out_sb    <= '0;
        end else if (en) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            // Bubbles leave the last delivered pixel on the outputs.
            if (s2_valid) begin
                out_bgr <= {sat(b_acc), sat(g_acc), sat(r_acc)};
                out_sb  <= s2_sb;
            end
        end
    end

endmodule

// File: tb/tb_yuv2bgr_pipe.sv
// ============================================================================
// tb_yuv2bgr_pipe
// ----------------------------------------------------------------------------
// Directed and randomised stimulus for yuv2bgr_pipe at DW=8, plus a DW=10
// instance for the wider offsets. Each accepted pixel pushes its expected
// {bgr, sb} onto a queue. A monitor pops one entry per consumed output and
// compares it. Expected pixels come either from hand-computed constants or
// from an integer model of the conversion equations.
// ============================================================================
module tb_yuv2bgr_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_sel709, out_valid, out_ready;
    logic [23:0] in_yuv, out_bgr;
    logic [1:0]  in_sb, out_sb;

    logic        in_valid_10, in_ready_10, out_valid_10, out_ready_10;
    logic [29:0] in_yuv_10, out_bgr_10;
    logic [1:0]  in_sb_10, out_sb_10;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          rnd_done;
    logic [25:0] sb_q[$];

    yuv2bgr_pipe #(.DW(8), .SB_W(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_yuv(in_yuv),
        .in_sel709(in_sel709), .in_sb(in_sb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bgr(out_bgr), .out_sb(out_sb)
    );

    yuv2bgr_pipe #(.DW(10), .SB_W(2)) dut10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_10), .in_ready(in_ready_10), .in_yuv(in_yuv_10),
        .in_sel709(1'b0), .in_sb(in_sb_10),
        .out_valid(out_valid_10), .out_ready(out_ready_10),
        .out_bgr(out_bgr_10), .out_sb(out_sb_10)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Integer reference of the conversion equations. Returns {B, G, R}.
    function automatic logic [35:0] model(input int dw, input int y, input int u,
                                          input int v, input bit sel);
        int s, yp, up, vp, r, g, b, mx;
        s  = dw - 8;
        yp = y - (16 << s);
        up = u - (128 << s);
        vp = v - (128 << s);
        r  = (4768 * yp + (sel ? 7344 : 6537) * vp + 2048) >>> 12;
        g  = (4768 * yp - (sel ? 872 : 1606) * up - (sel ? 2183 : 3330) * vp + 2048) >>> 12;
        b  = (4768 * yp + (sel ? 8651 : 8262) * up + 2048) >>> 12;
        mx = (1 << dw) - 1;
        r  = (r < 0) ? 0 : (r > mx) ? mx : r;
        g  = (g < 0) ? 0 : (g > mx) ? mx : g;
        b  = (b < 0) ? 0 : (b > mx) ? mx : b;
        return (36'(b) << (2 * dw)) | (36'(g) << dw) | 36'(r);
    endfunction

    // Inputs change 1 ns after the rising edge. Outputs are sampled on the
    // falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                        input bit sel, input logic [1:0] sb, input logic [23:0] exp);
        int n;
        n         = 0;
        in_yuv    = {y, u, v};
        in_sel709 = sel;
        in_sb     = sb;
        in_valid  = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            tick();
            #1;
            n++;
        end
        chk("accept_ready", 64'(in_ready), 64'd1);
        sb_q.push_back({exp, sb});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                              input bit sel, input logic [1:0] sb);
        logic [35:0] m;
        m = model(8, int'(y), int'(u), int'(v), sel);
        send(y, u, v, sel, sb, m[23:0]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk("drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic send10(input logic [9:0] y, input logic [9:0] u, input logic [9:0] v,
                          input logic [29:0] exp);
        int n;
        in_yuv_10   = {y, u, v};
        in_valid_10 = 1'b1;
        #1;
        chk("dw10_ready", 64'(in_ready_10), 64'd1);
        tick();
        in_valid_10 = 1'b0;
        n = 0;
        while (!out_valid_10 && n < 20) begin
            tick();
            n++;
        end
        chk("dw10_latency", 64'(n), 64'd2);
        chk("dw10_bgr", 64'(out_bgr_10), 64'(exp));
    endtask

    // Scoreboard monitor: a pixel shown while out_ready is high is consumed
    // at the next rising edge.
    always @(negedge clk) begin
        logic [25:0] e;
        if (!rst && out_valid && out_ready) begin
            chk("scoreboard_nonempty", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pixel", 64'({out_bgr, out_sb}), 64'(e));
            end
        end
    end

    initial begin : main
        int          lat;
        logic [35:0] m10;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_yuv       = '0;
        in_sel709    = 1'b0;
        in_sb        = '0;
        out_ready    = 1'b1;
        in_valid_10  = 1'b0;
        in_yuv_10    = '0;
        in_sb_10     = '0;
        out_ready_10 = 1'b1;
        rnd_done     = 1'b0;
        repeat (2) tick();

        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_bgr",   64'(out_bgr),   64'd0);
        chk("reset_out_sb",    64'(out_sb),    64'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Black. out_valid rises two edges after the acceptance edge, which
        // is three cycles after the pixel is presented.
        send(8'd16, 8'd128, 8'd128, 1'b0, 2'd1, 24'h000000);
        lat = 0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("latency", 64'(lat), 64'd2);

        // White, saturated red, high saturation on both matrices.
        send(8'd235, 8'd128, 8'd128, 1'b0, 2'd2, 24'hFFFFFF);
        send(8'd81,  8'd90,  8'd240, 1'b0, 2'd3, {8'd0, 8'd0, 8'd254});
        send(8'd255, 8'd255, 8'd255, 1'b0, 2'd0, {8'd255, 8'd125, 8'd255});
        send(8'd255, 8'd255, 8'd255, 1'b1, 2'd1, {8'd255, 8'd183, 8'd255});
        drain();

        // Matrix alternating on every pixel, back to back.
        for (int i = 0; i < 6; i++) begin
            logic [1:0] sbi;
            sbi = 2'(i);
            send_model(8'd128, 8'd200, 8'd60, sbi[0], sbi);
        end
        drain();

        // Burst of 10 with a 5-cycle downstream stall starting at cycle 4.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [1:0] sbi;
                    sbi = 2'(i);
                    send_model(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), sbi);
                end
            end
            begin
                logic [23:0] snap;
                logic [1:0]  snap_sb;
                repeat (4) tick();
                out_ready = 1'b0;
                #1;
                snap    = out_bgr;
                snap_sb = out_sb;
                for (int k = 0; k < 5; k++) begin
                    chk("stall_in_ready",  64'(in_ready),  64'd0);
                    chk("stall_out_valid", 64'(out_valid), 64'd1);
                    chk("stall_hold",      64'({out_bgr, out_sb}), 64'({snap, snap_sb}));
                    tick();
                    if (k < 4) #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Random pixels with random backpressure.
        fork
            begin
                for (int i = 0; i < 150; i++)
                    send_model(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three pixels in flight.
        out_ready = 1'b0;
        send_model(8'd100, 8'd50,  8'd200, 1'b0, 2'd1);
        send_model(8'd150, 8'd180, 8'd90,  1'b1, 2'd2);
        send_model(8'd200, 8'd30,  8'd30,  1'b0, 2'd3);
        chk("full_before_rst", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_bgr",   64'(out_bgr),   64'd0);
        chk("rst_out_sb",    64'(out_sb),    64'd0);
        rst = 1'b0;
        sb_q.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("no_ghost", 64'(out_valid), 64'd0);
        end

        // DW=10 instance.
        send10(10'd64, 10'd512, 10'd512, 30'd0);
        m10 = model(10, 940, 960, 64, 1'b0);
        send10(10'd940, 10'd960, 10'd64, m10[29:0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
